snake_game_sequencer: RTL
=========================

Name: snake_game_sequencer

Overview:
Top-level game flow controller for the Snake FPGA design. Sequences the game through idle, board clear, play and game-over phases, and generates the board-clear pulse and move ticks for the snake engine. Schedules move rate from score: each food shortens the move period down to a floor. Sits between the user inputs (start button, collision/food flags from the snake engine) and the snake/display datapath.

Parameters:
TICK_DIV_INIT, 25000000, initial move period in clock cycles (0.5 s at 50 MHz)
TICK_DIV_MIN, 5000000, minimum move period (floor)
TICK_DIV_STEP, 1000000, period decrement per food eaten
CLR_CYCLES, 16, length of game_clear pulse in cycles
OVER_HOLD_CYCLES, 50000000, cycles in OVER before a restart is accepted
SCORE_W, 8, score/high-score width

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
start_btn  in  1  start button level, already synchronised/debounced
collision  in  1  collision flag from snake engine (level or pulse)
food_eaten  in  1  one-cycle pulse per food eaten
game_clear  out  1  high while board/snake is being reinitialised
move_tick  out  1  one-cycle pulse: advance snake one cell
game_over  out  1  high in OVER state
state  out  3  current state encoding
score  out  SCORE_W  current score
high_score  out  SCORE_W  best score since reset

Behaviour:
- Interface decided: one clock named clock; reset named reset is synchronous and active-high.
- Reset: state=IDLE(0); game_clear, move_tick, game_over=0; score=0; high_score=0; period=TICK_DIV_INIT; all counters 0; start edge detector prev=0. Reset mid-operation aborts any state the same way.
- Start edge: registered rising edge of start_btn (prev=0, now=1). A held button yields exactly one edge.
- IDLE(0): outputs idle. Start edge -> CLEAR next cycle.
- CLEAR(1): on entry score=0, period=TICK_DIV_INIT, tick counter=0. game_clear=1 for exactly CLR_CYCLES cycles, then -> PLAY. Inputs ignored.
- PLAY(2): tick counter increments each cycle; when counter==period-1, move_tick=1 for that cycle and counter wraps to 0. First tick occurs period cycles after PLAY entry.
  - food_eaten: score+1, saturating at 2^SCORE_W-1; period=max(period-TICK_DIV_STEP, TICK_DIV_MIN), computed without underflow. The new period applies from the next comparison; the counter is not reset. If the counter is already >= the new period-1, the tick fires on the next cycle.
  - collision: -> OVER next cycle. move_tick is suppressed in the collision cycle. A simultaneous food_eaten is discarded (collision wins).
  - Start edge: ignored (see optional feature).
- OVER(3): game_over=1, move_tick=0. On the entry cycle, if score>high_score then high_score<=score (visible the cycle after entry). Hold counter runs OVER_HOLD_CYCLES cycles; start edges during the hold are discarded, not queued. After the hold, a start edge -> CLEAR.
- Latency: collision in cycle n -> state=OVER and game_over=1 in cycle n+1.
- Encodings 5–7 are unreachable; if entered, return to IDLE next cycle.

Optional Feature:
SNAKE_PAUSE_EN
- Defined: a start edge in PLAY -> PAUSE(4). In PAUSE the tick counter is frozen, move_tick=0, and food/collision are ignored. A start edge in PAUSE -> PLAY with the counter resumed where it stopped.
- Undefined: PAUSE does not exist; a start edge in PLAY is ignored.

Decomposition:
- Package snake_game_pkg: state encodings (IDLE=0, CLEAR=1, PLAY=2, OVER=3, PAUSE=4), STATE_W=3, tick-counter width constant derived via $clog2(TICK_DIV_INIT+1).
- Sub-module snake_tick_divider: programmable-period counter with enable, clear and period input, producing a tick pulse. The top module owns the FSM, score and period scheduling.

Test Plan:
(Bench params: TICK_DIV_INIT=10, TICK_DIV_MIN=4, TICK_DIV_STEP=2, CLR_CYCLES=3, OVER_HOLD_CYCLES=20, SCORE_W=4)
- Reset 2 cycles, then start edge -> state=1 next cycle; game_clear high exactly 3 cycles; state=2 after; score=0.
- PLAY with no events -> move_tick pulses every 10 cycles, first 10 cycles after PLAY entry, each 1 cycle wide.
- 4 food pulses -> score=4; period steps 10->8->6->4->4; 16 more foods -> score saturates at 15.
- collision coincident with food_eaten and tick cycle -> state=3 next cycle; score unchanged; no move_tick; high_score=score one cycle later; lower score in the next game leaves high_score unchanged.
- In OVER: start edge at hold cycle 10 -> stays OVER; button held high across hold expiry -> no restart; fresh edge after 20 cycles -> CLEAR.
- Reset asserted mid-PLAY with score=7, high_score=9 -> next cycle state=0, score=0, high_score=0, move_tick=0; with SNAKE_PAUSE_EN: start edge in PLAY freezes ticks, second edge resumes at the same counter value.

Source files
------------

// File: rtl/snake_game_pkg.sv
// snake_game_pkg: shared state encodings, widths and move-period scheduling helper
package snake_game_pkg;
    localparam int STATE_W           = 3;
    localparam int TICK_DIV_INIT_DEF = 25000000;
    localparam int CNT_W             = $clog2(TICK_DIV_INIT_DEF + 1);

    typedef enum logic [STATE_W-1:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_PLAY  = 3'd2,
        S_OVER  = 3'd3,
        S_PAUSE = 3'd4
    } state_t;

    function automatic logic [CNT_W-1:0] next_period(input logic [CNT_W-1:0] p, input int unsigned step,
                                                     input int unsigned floor_p);
        return (p >= CNT_W'(floor_p + step)) ? p - CNT_W'(step) : CNT_W'(floor_p);
    endfunction
endpackage

// File: rtl/snake_game_if.sv
// snake_game_if: user/engine inputs and game status outputs of the sequencer
interface snake_game_if #(parameter int SCORE_W = 8);
    import snake_game_pkg::*;
    logic               start_btn, collision, food_eaten;
    logic               game_clear, move_tick, game_over;
    logic [STATE_W-1:0] state;
    logic [SCORE_W-1:0] score, high_score;

    modport master (output start_btn, collision, food_eaten,
                    input  game_clear, move_tick, game_over, state, score, high_score);
    modport slave  (input  start_btn, collision, food_eaten,
                    output game_clear, move_tick, game_over, state, score, high_score);
endinterface

// File: rtl/snake_tick_divider.sv
// snake_tick_divider: programmable-period cycle counter emitting a one-cycle tick on wrap
module snake_tick_divider
    import snake_game_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             i_en,
    input  logic             i_clr,
    input  logic [CNT_W-1:0] i_period,
    output logic             o_tick
);
    logic [CNT_W-1:0] r_cnt;
    logic             w_wrap;

    // >= rather than == so a period that shrank below the count fires right away
    assign w_wrap = r_cnt >= i_period - CNT_W'(1);
    assign o_tick = i_en & w_wrap;

    always_ff @(posedge clock) begin
        if (reset || i_clr)
            r_cnt <= '0;
        else if (i_en)
            r_cnt <= w_wrap ? '0 : r_cnt + CNT_W'(1);
    end
endmodule

// File: rtl/snake_game_sequencer.sv
// snake_game_sequencer: game flow FSM with score-driven move rate; SNAKE_PAUSE_EN adds a PAUSE state
module snake_game_sequencer
    import snake_game_pkg::*;
#(
    parameter int TICK_DIV_INIT    = TICK_DIV_INIT_DEF,
    parameter int TICK_DIV_MIN     = 5000000,
    parameter int TICK_DIV_STEP    = 1000000,
    parameter int CLR_CYCLES       = 16,
    parameter int OVER_HOLD_CYCLES = 50000000,
    parameter int SCORE_W          = 8
) (
    input logic         clock,
    input logic         reset,
    snake_game_if.slave bus
);
    localparam int PH_MAX = (CLR_CYCLES > OVER_HOLD_CYCLES) ? CLR_CYCLES : OVER_HOLD_CYCLES;
    localparam int PH_W   = $clog2(PH_MAX + 1);

    state_t             r_state, w_next;
    logic               r_prev, w_start_edge, w_enter_clr, w_play_en, w_food, w_tick;
    logic [PH_W-1:0]    r_ph_cnt;
    logic [SCORE_W-1:0] r_score, r_high;
    logic [CNT_W-1:0]   r_period;

    assign w_start_edge = bus.start_btn & ~r_prev;
    assign w_enter_clr  = (w_next == S_CLEAR) && (r_state != S_CLEAR);
    assign w_play_en    = (r_state == S_PLAY) && !bus.collision;
    assign w_food       = w_play_en && bus.food_eaten;

    snake_tick_divider u_div (
        .clock    (clock),
        .reset    (reset),
        .i_en     (w_play_en),
        .i_clr    (w_enter_clr),
        .i_period (r_period),
        .o_tick   (w_tick)
    );

    always_ff @(posedge clock) r_state <= reset ? S_IDLE : w_next;

    always_comb begin
        w_next         = r_state;
        bus.game_clear = (r_state == S_CLEAR);
        bus.game_over  = (r_state == S_OVER);
        bus.move_tick  = w_tick;
        bus.state      = r_state;
        bus.score      = r_score;
        bus.high_score = r_high;
        case (r_state)
            S_IDLE:  w_next = w_start_edge ? S_CLEAR : S_IDLE;
            S_CLEAR: w_next = (r_ph_cnt == PH_W'(CLR_CYCLES - 1)) ? S_PLAY : S_CLEAR;
`ifdef SNAKE_PAUSE_EN
            S_PLAY:  w_next = bus.collision ? S_OVER : (w_start_edge ? S_PAUSE : S_PLAY);
            S_PAUSE: w_next = w_start_edge ? S_PLAY : S_PAUSE;
`else
            S_PLAY:  w_next = bus.collision ? S_OVER : S_PLAY;
`endif
            // edges inside the hold window are dropped, not remembered
            S_OVER:  w_next = (w_start_edge && r_ph_cnt >= PH_W'(OVER_HOLD_CYCLES)) ? S_CLEAR : S_OVER;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_prev   <= 1'b0;
            r_ph_cnt <= '0;
            r_score  <= '0;
            r_high   <= '0;
            r_period <= CNT_W'(TICK_DIV_INIT);
        end else begin
            r_prev   <= bus.start_btn;
            r_ph_cnt <= (w_next != r_state) ? '0 : r_ph_cnt + PH_W'(r_ph_cnt != '1);
            if (w_enter_clr) begin
                r_score  <= '0;
                r_period <= CNT_W'(TICK_DIV_INIT);
            end else if (w_food) begin
                r_score  <= r_score + SCORE_W'(r_score != '1);
                r_period <= next_period(r_period, TICK_DIV_STEP, TICK_DIV_MIN);
            end
            if (r_state == S_OVER && r_score > r_high)
                r_high <= r_score;
        end
    end
endmodule
